// File: rtl/watchdog_reset_req_if.sv
// Service/status bundle between the watchdog and the logic that kicks it.
// CW must match the watchdog's count width, $clog2(TimeoutCycles).
interface watchdog_reset_req_if #(
    parameter int CW = 10
);
    logic          enable;
    logic          kick;
    logic          clear;
    logic          rst_req_n;
    logic [1:0]    cause;
    logic [CW-1:0] count;

    modport master (
        output enable,
        output kick,
        output clear,
        input  rst_req_n,
        input  cause,
        input  count
    );

    modport slave (
        input  enable,
        input  kick,
        input  clear,
        output rst_req_n,
        output cause,
        output count
    );
endinterface

// File: rtl/watchdog_reset_req.sv
// Windowed watchdog: a missed or early kick produces a fixed-length, registered,
// active-low reset request for the system reset generator.
module watchdog_reset_req #(
    parameter int TimeoutCycles = 1024,
    parameter int WindowCycles  = 0,
    parameter int PulseCycles   = 16
) (
    input logic                 clk,
    input logic                 rst,
    watchdog_reset_req_if.slave wd
);
    localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int PW = (PulseCycles > 1) ? $clog2(PulseCycles) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIRE = 2'd2;

    localparam logic [CW-1:0] COUNT_LAST = CW'(TimeoutCycles - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PulseCycles - 1);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("watchdog_reset_req: TimeoutCycles must be >= 2");
    end
    if (PulseCycles < 1) begin : g_bad_pulse
        $error("watchdog_reset_req: PulseCycles must be >= 1");
    end
    if (WindowCycles >= TimeoutCycles) begin : g_bad_window
        $error("watchdog_reset_req: WindowCycles must be < TimeoutCycles");
    end

    logic [1:0]    state, state_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] pulse_cnt, pulse_next;
    logic [1:0]    cause, set_cause;
    logic          rst_req_n;
    logic          early;

    // With no window every kick is legal, so the comparison is dropped entirely.
    if (WindowCycles == 0) begin : g_no_window
        assign early = 1'b0;
    end else begin : g_window
        localparam logic [CW-1:0] WIN = CW'(WindowCycles);
        assign early = (count < WIN);
    end

    always_comb begin
        state_next = state;
        count_next = count;
        pulse_next = pulse_cnt;
        set_cause  = 2'b00;
        case (state)
            IDLE: begin
                count_next = '0;
                if (wd.enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!wd.enable) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (wd.kick && early) begin
                    state_next   = FIRE;
                    set_cause[1] = 1'b1;
                    count_next   = '0;
                    pulse_next   = '0;
                end else if (wd.kick) begin
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next   = FIRE;
                    set_cause[0] = 1'b1;
                    count_next   = '0;
                    pulse_next   = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            FIRE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = IDLE;
                    pulse_next = '0;
                end else begin
                    pulse_next = pulse_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                pulse_next = '0;
            end
        endcase
    end

    // rst_req_n is registered from the next state so it is low exactly while in FIRE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            pulse_cnt <= '0;
            rst_req_n <= 1'b1;
            cause     <= 2'b00;
        end else begin
            state     <= state_next;
            count     <= count_next;
            pulse_cnt <= pulse_next;
            rst_req_n <= (state_next != FIRE);
            cause     <= (wd.clear ? 2'b00 : cause) | set_cause;
        end
    end

    assign wd.rst_req_n = rst_req_n;
    assign wd.cause     = cause;
    assign wd.count     = count;
endmodule
